// File: rtl/servant_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one RAM port between SERV ibus and dbus.
// Optional ack timeout is enabled with the ARB_TIMEOUT_EN macro.
module servant_wb_rr_arbiter #(
    parameter int          AW             = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] i_wb_ibus_adr,
    input  logic          i_wb_ibus_cyc,
    output logic [31:0]   o_wb_ibus_rdt,
    output logic          o_wb_ibus_ack,
    input  logic [AW-1:0] i_wb_dbus_adr,
    input  logic [31:0]   i_wb_dbus_dat,
    input  logic [3:0]    i_wb_dbus_sel,
    input  logic          i_wb_dbus_we,
    input  logic          i_wb_dbus_cyc,
    output logic [31:0]   o_wb_dbus_rdt,
    output logic          o_wb_dbus_ack,
    output logic [AW-1:0] o_wb_mem_adr,
    output logic [31:0]   o_wb_mem_dat,
    output logic [3:0]    o_wb_mem_sel,
    output logic          o_wb_mem_we,
    output logic          o_wb_mem_cyc,
    input  logic [31:0]   i_wb_mem_rdt,
    input  logic          i_wb_mem_ack,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_dbus;
    logic   w_gnt_i;
    logic   w_gnt_d;
    logic   w_cyc;
    logic   w_ack;
    logic   w_timeout;

    // Reset masks the grant immediately so nothing leaks out while wb_rst is high.
    assign w_gnt_i = (r_state == GNT_I) && !wb_rst;
    assign w_gnt_d = (r_state == GNT_D) && !wb_rst;
    assign w_cyc   = (w_gnt_i && i_wb_ibus_cyc) || (w_gnt_d && i_wb_dbus_cyc);
    assign w_ack   = w_cyc && i_wb_mem_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // A real ack in the same cycle wins over the forced completion.
    assign w_timeout = w_cyc && !i_wb_mem_ack && (r_cnt == CW'(TIMEOUT_CYCLES));
    assign o_timeout = r_timeout;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (!i_wb_mem_ack)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_wb_mem_cyc = w_cyc && !w_timeout;
    assign o_wb_mem_adr = w_gnt_i ? i_wb_ibus_adr : (w_gnt_d ? i_wb_dbus_adr : '0);
    assign o_wb_mem_dat = w_gnt_d ? i_wb_dbus_dat : 32'h0;
    assign o_wb_mem_sel = w_gnt_i ? 4'hF : (w_gnt_d ? i_wb_dbus_sel : 4'h0);
    assign o_wb_mem_we  = w_gnt_d && i_wb_dbus_we;

    assign o_wb_ibus_ack = w_gnt_i && (w_ack || w_timeout);
    assign o_wb_dbus_ack = w_gnt_d && (w_ack || w_timeout);
    assign o_wb_ibus_rdt = (w_gnt_i && w_timeout) ? ERR_DATA : i_wb_mem_rdt;
    assign o_wb_dbus_rdt = (w_gnt_d && w_timeout) ? ERR_DATA : i_wb_mem_rdt;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state     <= IDLE;
            r_last_dbus <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_wb_ibus_cyc && (!i_wb_dbus_cyc || r_last_dbus))
                        r_state <= GNT_I;
                    else if (i_wb_dbus_cyc)
                        r_state <= GNT_D;
                end
                GNT_I: begin
                    // Completion, abort or timeout all release the port.
                    if (!i_wb_ibus_cyc || w_ack || w_timeout) begin
                        r_state     <= IDLE;
                        r_last_dbus <= 1'b0;
                    end
                end
                GNT_D: begin
                    if (!i_wb_dbus_cyc || w_ack || w_timeout) begin
                        r_state     <= IDLE;
                        r_last_dbus <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servant_wb_rr_arbiter.sv
// Self-checking bench for servant_wb_rr_arbiter: directed plan steps, then random traffic
// compared against an owner/last-winner reference model.
module tb_servant_wb_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    localparam int NONE = 0, IB = 1, DB = 2;

    logic        clk = 1'b0;
    logic        rst, icyc, dcyc, dwe, mack;
    logic [31:0] iadr, dadr, ddat, mrdt;
    logic [3:0]  dsel;
    logic [31:0] o_irdt, o_drdt, o_madr, o_mdat;
    logic        o_iack, o_dack, o_mwe, o_mcyc, o_to;
    logic [3:0]  o_msel;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    int m_owner = NONE;
    int m_last  = DB;
    int m_wait  = 0;
    bit m_to    = 1'b0;

    always #5 clk = ~clk;

    servant_wb_rr_arbiter #(.AW(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .wb_clk(clk), .wb_rst(rst),
        .i_wb_ibus_adr(iadr), .i_wb_ibus_cyc(icyc),
        .o_wb_ibus_rdt(o_irdt), .o_wb_ibus_ack(o_iack),
        .i_wb_dbus_adr(dadr), .i_wb_dbus_dat(ddat), .i_wb_dbus_sel(dsel),
        .i_wb_dbus_we(dwe), .i_wb_dbus_cyc(dcyc),
        .o_wb_dbus_rdt(o_drdt), .o_wb_dbus_ack(o_dack),
        .o_wb_mem_adr(o_madr), .o_wb_mem_dat(o_mdat), .o_wb_mem_sel(o_msel),
        .o_wb_mem_we(o_mwe), .o_wb_mem_cyc(o_mcyc),
        .i_wb_mem_rdt(mrdt), .i_wb_mem_ack(mack),
        .o_timeout(o_to)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_timeout(input bit master_cyc);
`ifdef ARB_TIMEOUT_EN
        return master_cyc && !mack && (m_wait == TO);
`else
        return 1'b0 && master_cyc;
`endif
    endfunction

    // Advance the model with the inputs that were stable across this edge.
    task automatic model_update();
        bit mc;
        bit tout;
        if (rst) begin
            m_owner = NONE; m_last = DB; m_wait = 0; m_to = 1'b0;
        end else if (m_owner == NONE) begin
            m_wait = 0;
            if (icyc && dcyc) m_owner = (m_last == DB) ? IB : DB;
            else if (icyc)    m_owner = IB;
            else if (dcyc)    m_owner = DB;
        end else begin
            mc   = (m_owner == IB) ? icyc : dcyc;
            tout = model_timeout(mc);
            if (!mc || mack || tout) begin
                m_last  = m_owner;
                m_owner = NONE;
                if (tout) m_to = 1'b1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc_no++;
        #1;
    endtask

    task automatic check_all();
        bit gi, gd, mc, tout, e_cyc, e_we, e_iack, e_dack;
        logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
        logic [3:0]  e_sel;
        #1;
        gi     = !rst && (m_owner == IB);
        gd     = !rst && (m_owner == DB);
        mc     = (gi && icyc) || (gd && dcyc);
        tout   = model_timeout(mc);
        e_cyc  = mc && !tout;
        e_adr  = gi ? iadr : (gd ? dadr : 32'h0);
        e_dat  = gd ? ddat : 32'h0;
        e_sel  = gi ? 4'hF : (gd ? dsel : 4'h0);
        e_we   = gd && dwe;
        e_iack = gi && icyc && (mack || tout);
        e_dack = gd && dcyc && (mack || tout);
        e_irdt = (gi && tout) ? ERR : mrdt;
        e_drdt = (gd && tout) ? ERR : mrdt;
        chk("mem_bus", {o_mcyc, o_madr, o_mdat, o_msel, o_mwe}, {e_cyc, e_adr, e_dat, e_sel, e_we});
        chk("ibus_ack", o_iack, e_iack);
        chk("dbus_ack", o_dack, e_dack);
        chk("ibus_rdt", o_irdt, e_irdt);
        chk("dbus_rdt", o_drdt, e_drdt);
        chk("timeout_flag", o_to, m_to);
        if (o_iack) $display("txn cyc=%0d ibus adr=%h rdt=%h", cyc_no, iadr, o_irdt);
        if (o_dack) $display("txn cyc=%0d dbus adr=%h we=%0d rdt=%h", cyc_no, dadr, dwe, o_drdt);
    endtask

    task automatic idle_inputs();
        icyc = 0; dcyc = 0; dwe = 0; mack = 0;
        iadr = 0; dadr = 0; ddat = 0; dsel = 0; mrdt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle_inputs();
        check_all();
        tick();
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int pend;
        int nack;
        int first_ack;
        int last_ack;
        logic [3:0] ord;

        rst = 1'b1; idle_inputs();
        #1;
        tick(); check_all();
        tick(); check_all();
        chk("reset_mem_cyc", o_mcyc, 1'b0);
        chk("reset_acks", {o_iack, o_dack}, 2'b00);

        // ibus-only fetch at 0x100
        rst = 1'b0; icyc = 1; iadr = 32'h0000_0100;
        check_all();
        chk("ifetch_wait", o_mcyc, 1'b0);
        tick(); check_all();
        chk("ifetch_bus", {o_mcyc, o_madr, o_mwe, o_msel}, {1'b1, 32'h100, 1'b0, 4'hF});
        mack = 1; mrdt = 32'h0000_0013;
        check_all();
        chk("ifetch_ack", {o_iack, o_dack, o_irdt}, {1'b1, 1'b0, 32'h13});
        tick(); icyc = 0; mack = 0; check_all();

        // continuous contention, slave acks one cycle after cyc
        tick(); do_reset();
        icyc = 1; dcyc = 1; iadr = 32'h1000; dadr = 32'h2000; ddat = 32'h1234_5678; dsel = 4'hC;
        pend = 0; nack = 0; ord = 4'h0; first_ack = 0; last_ack = 0;
        for (int i = 0; i < 30 && nack < 4; i++) begin
            tick();
            mack = (pend != 0); mrdt = $urandom;
            check_all();
            if (o_iack || o_dack) begin
                ord = {ord[2:0], o_dack};
                if (nack == 0) first_ack = cyc_no;
                last_ack = cyc_no;
                nack++;
            end
            pend = (o_mcyc && !mack) ? 1 : 0;
        end
        chk("rr_order", {nack[3:0], ord}, {4'd4, 4'b0101});
        chk("rr_spacing", last_ack - first_ack, 9);
        tick(); idle_inputs(); check_all();

        // dbus write
        tick(); dcyc = 1; dwe = 1; dadr = 32'h200; ddat = 32'hA5A5A5A5; dsel = 4'b0011;
        check_all();
        chk("dwrite_ibus_ack", o_iack, 1'b0);
        tick(); check_all();
        chk("dwrite_bus", {o_mcyc, o_madr, o_mdat, o_msel, o_mwe},
            {1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011, 1'b1});
        mack = 1; check_all();
        chk("dwrite_ack", {o_dack, o_iack}, 2'b10);
        tick(); idle_inputs(); check_all();

        // reset while dbus holds the grant with ack pending
        tick(); dcyc = 1; dadr = 32'h400; check_all();
        tick(); check_all();
        chk("pre_rst_gnt_d", o_mcyc, 1'b1);
        rst = 1; mack = 1; check_all();
        chk("rst_no_ack", {o_mcyc, o_dack, o_iack}, 3'b000);
        tick(); rst = 0; mack = 0; icyc = 1; iadr = 32'h300; check_all();
        chk("post_rst_idle", o_mcyc, 1'b0);
        tick(); check_all();
        chk("post_rst_ibus_first", {o_mcyc, o_madr}, {1'b1, 32'h300});
        mack = 1; check_all();
        tick(); idle_inputs(); check_all();

        // spurious ack in IDLE, then dbus abort
        tick(); mack = 1; mrdt = 32'h5555_AAAA; check_all();
        chk("spurious_ack", {o_iack, o_dack}, 2'b00);
        tick(); mack = 0; dcyc = 1; dadr = 32'h500; check_all();
        tick(); check_all();
        chk("abort_gnt", o_mcyc, 1'b1);
        dcyc = 0; check_all();
        chk("abort_no_ack", {o_mcyc, o_dack}, 2'b00);
        tick(); check_all();
        tick(); check_all();

`ifdef ARB_TIMEOUT_EN
        tick(); do_reset();
        icyc = 1; iadr = 32'h600;
        nack = 0; pend = 0;
        for (int i = 0; i < 20 && nack == 0; i++) begin
            tick(); check_all();
            if (o_mcyc) pend++;
            if (o_iack) begin
                nack = 1;
                chk("timeout_rdt", o_irdt, ERR);
            end
        end
        chk("timeout_cycles", {nack, pend}, {32'd1, 32'd8});
        tick(); icyc = 0; check_all();
        for (int i = 0; i < 4; i++) begin
            tick(); check_all();
            chk("timeout_sticky", o_to, 1'b1);
        end
        tick(); do_reset();
        chk("timeout_cleared", o_to, 1'b0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst  = ($urandom_range(63) == 0);
            icyc = ($urandom_range(3) != 0);
            dcyc = ($urandom_range(3) != 0);
            iadr = $urandom; dadr = $urandom; ddat = $urandom;
            dsel = 4'($urandom); dwe = 1'($urandom);
            mack = ($urandom_range(9) < 3);
            mrdt = $urandom;
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
